// File: rtl/left_shift_pipe_pkg.sv
// Shared defaults and types for the pipelined left shifter.
package left_shift_pipe_pkg;

  // Default datapath width; the offset width and the stage count both follow from it.
  localparam int unsigned LSP_WIDTH   = 16;
  localparam int unsigned LSP_SHAMT_W = $clog2(LSP_WIDTH);

  // One pipeline slot: shifted data, overflow so far, occupancy and the offset bits
  // still to be applied by later stages.
  typedef struct packed {
    logic [LSP_WIDTH-1:0]   data;
    logic                   ovf;
    logic                   valid;
    logic [LSP_SHAMT_W-1:0] offset;
  } stage_t;

  // Shift distance handled by stage k.
  function automatic int unsigned stage_shift(input int unsigned k);
    return 32'd1 << k;
  endfunction

endpackage

// File: rtl/left_shift_pipe_if.sv
// Operand/result handshake bundle for left_shift_pipe.
interface left_shift_pipe_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
);

  logic [WIDTH-1:0]   in;
  logic [SHAMT_W-1:0] offset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out;
  logic               out_ovf;
  logic               out_valid;
  logic               out_ready;

  // Producer of operands and consumer of results.
  modport master (
    output in,
    output offset,
    output in_valid,
    input  in_ready,
    input  out,
    input  out_ovf,
    input  out_valid,
    output out_ready
  );

  // The shifter itself.
  modport slave (
    input  in,
    input  offset,
    input  in_valid,
    output in_ready,
    output out,
    output out_ovf,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/left_shift_stage.sv
// One registered stage of the left shifter: conditionally shifts by SHIFT bits,
// accumulates the overflow flag and retires its offset bit.
module left_shift_stage #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4,
  parameter int unsigned SHIFT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logic [WIDTH-1:0]   prev_data,
  input  logic               prev_ovf,
  input  logic               prev_valid,
  input  logic [SHAMT_W-1:0] prev_offset,
  output logic [WIDTH-1:0]   data,
  output logic               ovf,
  output logic               valid,
  output logic [SHAMT_W-1:0] offset
);

  // Offset bit this stage consumes.
  localparam int unsigned BIT = $clog2(SHIFT);

  logic               sel;
  logic [WIDTH-1:0]   shifted;
  logic               lost;
  logic [WIDTH-1:0]   data_d;
  logic               ovf_d;
  logic [SHAMT_W-1:0] offset_d;

  assign sel = prev_offset[BIT];

  // Shifted candidate, bits pushed past the MSB, and the 2:1 select.
  always_comb begin
    shifted  = {prev_data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
    lost     = |prev_data[WIDTH-1 -: SHIFT];
    data_d   = sel ? shifted : prev_data;
    ovf_d    = prev_ovf | (sel & lost);
    // Clear the consumed bit so the residual only holds what later stages still apply.
    offset_d      = prev_offset;
    offset_d[BIT] = 1'b0;
  end

  // Stage register; a capture with prev_valid low loads a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      data   <= '0;
      ovf    <= 1'b0;
      valid  <= 1'b0;
      offset <= '0;
    end else if (capture) begin
      data   <= data_d;
      ovf    <= ovf_d;
      valid  <= prev_valid;
      offset <= offset_d;
    end
  end

endmodule

// File: rtl/left_shift_pipe.sv
// Pipelined logical left shifter: SHAMT_W registered stages shifting by 1, 2, 4, ...
// with a valid/ready elastic chain that squeezes out bubbles under backpressure.
module left_shift_pipe
  import left_shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH   = LSP_WIDTH,
  parameter int unsigned SHAMT_W = LSP_SHAMT_W
) (
  input logic              clk,
  input logic              rst,
  left_shift_pipe_if.slave bus
);

  // Index 0 is the input port; index k+1 is the register of stage k.
  logic [WIDTH-1:0]   pipe_data [SHAMT_W+1];
  logic [SHAMT_W-1:0] pipe_off  [SHAMT_W+1];
  logic [SHAMT_W:0]   pipe_ovf;
  logic [SHAMT_W:0]   pipe_valid;
  logic [SHAMT_W-1:0] stage_valid;
  logic [SHAMT_W-1:0] advance;
  logic               full_from;
  logic               unused_off;

  assign pipe_data[0]  = bus.in;
  assign pipe_off[0]   = bus.offset;
  assign pipe_ovf[0]   = 1'b0;
  assign pipe_valid[0] = bus.in_valid;
  assign stage_valid   = pipe_valid[SHAMT_W:1];

  // Every offset bit is consumed by the last stage, so its residual is always zero.
  assign unused_off = ^pipe_off[SHAMT_W];

  // Stage k may capture unless it and every stage after it are full while the
  // output is stalled; written in closed form to keep the chain free of feedback.
  always_comb begin
    advance   = '0;
    full_from = 1'b1;
    for (int k = 0; k < SHAMT_W; k++) begin
      full_from = 1'b1;
      for (int j = k; j < SHAMT_W; j++) begin
        full_from = full_from & stage_valid[j];
      end
      advance[k] = bus.out_ready | ~full_from;
    end
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    left_shift_stage #(
      .WIDTH  (WIDTH),
      .SHAMT_W(SHAMT_W),
      .SHIFT  (stage_shift(k))
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .capture    (advance[k]),
      .prev_data  (pipe_data[k]),
      .prev_ovf   (pipe_ovf[k]),
      .prev_valid (pipe_valid[k]),
      .prev_offset(pipe_off[k]),
      .data       (pipe_data[k+1]),
      .ovf        (pipe_ovf[k+1]),
      .valid      (pipe_valid[k+1]),
      .offset     (pipe_off[k+1])
    );
  end

  // Nothing is accepted while reset is held, so data on the reset cycle is dropped.
  assign bus.in_ready  = advance[0] & ~rst;
  assign bus.out       = pipe_data[SHAMT_W];
  assign bus.out_ovf   = pipe_ovf[SHAMT_W];
  assign bus.out_valid = pipe_valid[SHAMT_W];

endmodule

// File: tb/tb_left_shift_pipe.sv
// Bench for left_shift_pipe: table vectors, streaming, backpressure, random traffic
// and mid-stream reset, all checked through an in-order scoreboard.
module tb_left_shift_pipe;
  import left_shift_pipe_pkg::*;

  typedef struct {
    logic [15:0] in;
    logic [3:0]  off;
    logic [15:0] out;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   n_out = 0;
  logic [15:0] exp_out = '0;
  logic        exp_ovf = 1'b0;
  stage_t sb[$];
  int     out_cyc[$];
  vec_t   tab[12];
  vec_t   bp[6];

  left_shift_pipe_if #(.WIDTH(16), .SHAMT_W(4)) bus ();

  left_shift_pipe #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: widen, shift, split into kept and lost halves.
  function automatic logic [16:0] model(input logic [15:0] d, input logic [3:0] o);
    logic [31:0] full;
    full = {16'h0000, d} << o;
    return {|full[31:16], full[15:0]};
  endfunction

  // Scoreboard: pop/compare on output transfer, push on input transfer.
  always @(negedge clk) begin
    stage_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL stray_out: got out=%h ovf=%b, expected no item", bus.out, bus.out_ovf);
        end else begin
          e = sb.pop_front();
          check("out_data", {16'h0, bus.out}, {16'h0, e.data});
          check("out_ovf", {31'h0, bus.out_ovf}, {31'h0, e.ovf});
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back('{data: exp_out, ovf: exp_ovf, valid: 1'b1, offset: bus.offset});
    end
  end

  // Present one item and hold it until accepted; entered and left at posedge+1.
  task automatic send(input logic [15:0] d, input logic [3:0] o, input logic [15:0] eo,
                      input logic eovf);
    int w;
    w = 0;
    bus.in = d; bus.offset = o; exp_out = eo; exp_ovf = eovf; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("send_timeout", 32'(w), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    while ((sb.size() != 0 || bus.out_valid) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic measure_latency(input logic [15:0] d, input logic [3:0] o,
                                 input logic [15:0] eo, input logic eovf, input string tag);
    int n;
    bus.in = d; bus.offset = o; exp_out = eo; exp_ovf = eovf; bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    check({tag, "_in_ready"}, {31'h0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      check({tag, "_in_ready_hold"}, {31'h0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
  endtask

  initial begin
    int base;
    logic [15:0] one_hot;
    logic [16:0] m;

    tab[0]  = '{16'h0001, 4'd5,  16'h0020, 1'b0};
    tab[1]  = '{16'h8001, 4'd1,  16'h0002, 1'b1};
    tab[2]  = '{16'hFFFF, 4'd15, 16'h8000, 1'b1};
    tab[3]  = '{16'h1234, 4'd0,  16'h1234, 1'b0};
    tab[4]  = '{16'h00FF, 4'd8,  16'hFF00, 1'b0};
    tab[5]  = '{16'h0F0F, 4'd4,  16'hF0F0, 1'b0};
    tab[6]  = '{16'h0F0F, 4'd5,  16'hE1E0, 1'b1};
    tab[7]  = '{16'hC000, 4'd1,  16'h8000, 1'b1};
    tab[8]  = '{16'h0003, 4'd15, 16'h8000, 1'b1};
    tab[9]  = '{16'h0001, 4'd15, 16'h8000, 1'b0};
    tab[10] = '{16'hA5A5, 4'd3,  16'h2D28, 1'b1};
    tab[11] = '{16'h1FFF, 4'd3,  16'hFFF8, 1'b0};

    bp[0] = '{16'h0001, 4'd1,  16'h0002, 1'b0};
    bp[1] = '{16'h0003, 4'd2,  16'h000C, 1'b0};
    bp[2] = '{16'h8001, 4'd1,  16'h0002, 1'b1};
    bp[3] = '{16'h00F0, 4'd4,  16'h0F00, 1'b0};
    bp[4] = '{16'hFFFF, 4'd15, 16'h8000, 1'b1};
    bp[5] = '{16'h1234, 4'd0,  16'h1234, 1'b0};

    bus.in = '0; bus.offset = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

    // Reset state.
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("rst_out", {16'h0, bus.out}, 32'd0);
    check("rst_out_ovf", {31'h0, bus.out_ovf}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Single item latency.
    measure_latency(16'h0001, 4'd5, 16'h0020, 1'b0, "single");
    drain();

    // Table vectors, back to back.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(tab[i].in, tab[i].off, tab[i].out, tab[i].ovf);
    drain();

    // Streaming one-hot walk; outputs must land on consecutive cycles.
    out_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      one_hot = 16'h0001 << i;
      send(16'h0001, 4'(i), one_hot, 1'b0);
    end
    drain();
    check("stream_count", 32'(out_cyc.size()), 32'd16);
    if (out_cyc.size() == 16) check("stream_span", 32'(out_cyc[15] - out_cyc[0]), 32'd15);

    // Backpressure: fill four slots, then the fifth must wait with a frozen output.
    base = n_out;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(bp[i].in, bp[i].off, bp[i].out, bp[i].ovf);
    bus.in = bp[4].in; bus.offset = bp[4].off; exp_out = bp[4].out; exp_ovf = bp[4].ovf;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'h0, bus.in_ready}, 32'd0);
      check("bp_out_valid", {31'h0, bus.out_valid}, 32'd1);
      check("bp_out_hold", {16'h0, bus.out}, 32'h0002);
      check("bp_ovf_hold", {31'h0, bus.out_ovf}, 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(bp[4].in, bp[4].off, bp[4].out, bp[4].ovf);
    send(bp[5].in, bp[5].off, bp[5].out, bp[5].ovf);
    drain();
    check("bp_count", 32'(n_out - base), 32'd6);

    // Random traffic with random stalls on both sides.
    for (int i = 0; i < 10000; i++) begin
      bus.in = 16'($urandom);
      bus.offset = 4'($urandom_range(0, 15));
      m = model(bus.in, bus.offset);
      exp_out = m[15:0]; exp_ovf = m[16];
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();

    // Mid-stream reset with three items in flight.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(tab[i].in, tab[i].off, tab[i].out, tab[i].ovf);
    rst = 1'b1;
    bus.in = 16'hDEAD; bus.offset = 4'd1; bus.in_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    check("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("mid_rst_out", {16'h0, bus.out}, 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    check("mid_rst_no_stale", 32'(n_out - base), 32'd0);
    measure_latency(16'h0F0F, 4'd5, 16'hE1E0, 1'b1, "after_rst");
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
